// File: rtl/simd_ram_arbiter.sv
// simd_ram_arbiter: shares the single-port vector data RAM between the SIMD
// processor data port and a host/loader port using round-robin arbitration.
module simd_ram_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 256,
    parameter int BW         = DW/8,
    parameter int RD_LATENCY = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] p_address,
    input  logic [BW-1:0] p_byteena,
    input  logic [DW-1:0] p_wdata,
    input  logic          p_rden,
    input  logic          p_wren,
    output logic [DW-1:0] p_rdata,
    output logic          p_stall,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_address,
    input  logic [BW-1:0] h_byteena,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic [AW-1:0] ram_address,
    output logic [BW-1:0] ram_byteena,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_rden,
    output logic          ram_wren,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
    typedef enum logic {OWN_PROC, OWN_HOST} owner_t;

    state_t        state;
    state_t        next_state;
    owner_t        owner;
    owner_t        last_owner;
    logic [2:0]    counter;
    logic [AW-1:0] addr_q;
    logic          preq;
    logic          p_win;
    logic          h_win;
    logic          grant_rd;
    logic          rd_capture;

    // Grants are only issued from IDLE and never while reset is held; on a tie
    // the side that did not own the RAM last time wins.
    always_comb begin
        preq  = p_rden | p_wren;
        p_win = 1'b0;
        h_win = 1'b0;
        if (reset && state == IDLE) begin
            if (preq && (!h_req || last_owner == OWN_HOST))
                p_win = 1'b1;
            else if (h_req)
                h_win = 1'b1;
        end
        grant_rd   = (p_win && !p_wren) || (h_win && !h_we);
        rd_capture = (state == RD_WAIT) && (counter == 3'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_rd) next_state = RD_WAIT;
            RD_WAIT: if (counter == 3'd0) next_state = RD_DONE;
            RD_DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ram_address = '0;
        ram_byteena = '0;
        ram_wdata   = '0;
        ram_rden    = 1'b0;
        ram_wren    = 1'b0;
        h_gnt       = 1'b0;
        h_rvalid    = (state == RD_DONE) && (owner == OWN_HOST);
        if (p_win) begin
            ram_address = p_address;
            ram_byteena = p_byteena;
            ram_wdata   = p_wdata;
            ram_wren    = p_wren;
            ram_rden    = !p_wren;
        end else if (h_win) begin
            ram_address = h_address;
            ram_byteena = h_byteena;
            ram_wdata   = h_wdata;
            ram_wren    = h_we;
            ram_rden    = !h_we;
            h_gnt       = 1'b1;
        end else if (state == RD_WAIT) begin
            ram_address = addr_q;
        end
        // RD_DONE releases a reading processor without re-issuing its still-high request.
        p_stall = preq && !((p_win && p_wren) || (state == RD_DONE && owner == OWN_PROC));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_HOST;
            owner      <= OWN_PROC;
            counter    <= '0;
            addr_q     <= '0;
            p_rdata    <= '0;
            h_rdata    <= '0;
        end else begin
            if (p_win)
                last_owner <= OWN_PROC;
            else if (h_win)
                last_owner <= OWN_HOST;
            if (grant_rd) begin
                owner   <= p_win ? OWN_PROC : OWN_HOST;
                addr_q  <= p_win ? p_address : h_address;
                counter <= 3'(RD_LATENCY - 1);
            end else if (state == RD_WAIT && counter != 3'd0) begin
                counter <= counter - 3'd1;
            end
            if (rd_capture) begin
                if (owner == OWN_HOST)
                    h_rdata <= ram_rdata;
                else
                    p_rdata <= ram_rdata;
            end
        end
    end

endmodule
